dcache_ctrl: RTL and testbench

//  Blocking 4KB direct-mapped, write-through, no-write-allocate data cache; downstream of the load/store queue.

---
 rtl/dcache_pkg.sv | 31 +++
 rtl/dcache_if.sv | 43 ++++
 rtl/dcache_array.sv | 54 +++++
 rtl/dcache_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and geometry helpers for the data cache
package dcache_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int CNTRL_W = 16;
  localparam int Z_W     = 4;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, WRITE} state_e;

  typedef struct packed {
    logic               rw;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
    logic [CNTRL_W-1:0] cntrl;
    logic [Z_W-1:0]     z;
  } req_t;

  function automatic int ofs_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int cache_bytes, input int line_words);
    return $clog2(cache_bytes / (4 * line_words));
  endfunction

  function automatic int tag_w(input int cache_bytes, input int line_words);
    return ADDR_W - idx_w(cache_bytes, line_words) - ofs_w(line_words) - 2;
  endfunction

endpackage

// File: rtl/dcache_if.sv
// rtl/dcache_if.sv - LSQ-side and memory-side bundles of the data cache
interface dcache_lsq_if;
  logic                             req_valid;
  logic                             req_rw;
  logic [dcache_pkg::ADDR_W-1:0]    req_addr;
  logic [dcache_pkg::DATA_W-1:0]    req_data;
  logic [dcache_pkg::CNTRL_W-1:0]   req_cntrl;
  logic [dcache_pkg::Z_W-1:0]       req_z;
  logic                             req_ready;
  logic                             resp_valid;
  logic [dcache_pkg::DATA_W-1:0]    resp_data;
  logic [dcache_pkg::CNTRL_W-1:0]   resp_cntrl;
  logic [dcache_pkg::Z_W-1:0]       resp_z;

  modport master (
    output req_valid, req_rw, req_addr, req_data, req_cntrl, req_z,
    input  req_ready, resp_valid, resp_data, resp_cntrl, resp_z
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_data, req_cntrl, req_z,
    output req_ready, resp_valid, resp_data, resp_cntrl, resp_z
  );
endinterface

interface dcache_mem_if;
  logic                          mem_req;
  logic                          mem_we;
  logic [dcache_pkg::ADDR_W-1:0] mem_addr;
  logic [dcache_pkg::DATA_W-1:0] mem_wdata;
  logic                          mem_ack;
  logic [dcache_pkg::DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - tag/data storage with a resettable valid vector
module dcache_array #(
  parameter int IDX_W = 8,
  parameter int OFS_W = 2,
  parameter int TAG_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [OFS_W-1:0] rd_ofs_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [31:0]      rd_data_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [OFS_W-1:0] wr_ofs_i,
  input  logic [31:0]      wr_data_i,
  input  logic             line_set_i,
  input  logic             line_clr_i,
  input  logic [TAG_W-1:0] line_tag_i
);

  localparam int LINES = 1 << IDX_W;
  localparam int WORDS = LINES << OFS_W;

  logic [31:0]      data_mem [WORDS];
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [LINES-1:0] valid_q;

  // Storage arrays carry no reset; only the valid bits define cache content.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      data_mem[{wr_idx_i, wr_ofs_i}] <= wr_data_i;
    end
    if (line_set_i) begin
      tag_mem[wr_idx_i] <= line_tag_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (line_set_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end else if (line_clr_i) begin
      valid_q[wr_idx_i] <= 1'b0;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_mem[rd_idx_i];
  assign rd_data_o  = data_mem[{rd_idx_i, rd_ofs_i}];

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - blocking direct-mapped write-through data cache controller
import dcache_pkg::*;

module dcache_ctrl #(
  parameter int CACHE_BYTES = 4096,
  parameter int LINE_WORDS  = 4
) (
  input  logic        clk,
  input  logic        rst,
  dcache_lsq_if.slave lsq,
  dcache_mem_if.master mem
);

  localparam int OFS_W = ofs_w(LINE_WORDS);
  localparam int IDX_W = idx_w(CACHE_BYTES, LINE_WORDS);
  localparam int TAG_W = tag_w(CACHE_BYTES, LINE_WORDS);

  state_e              state_q, state_d;
  req_t                req_q, req_d;
  logic [OFS_W-1:0]    cnt_q, cnt_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic [CNTRL_W-1:0]  resp_cntrl_q, resp_cntrl_d;
  logic [Z_W-1:0]      resp_z_q, resp_z_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [IDX_W-1:0]    idx;
  logic [OFS_W-1:0]    ofs;
  logic [TAG_W-1:0]    tag;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [DATA_W-1:0]   rd_data;
  logic                hit, ack_seen, last_word, req_ready;
  logic                arr_wr_en, line_set, line_clr;
  logic [OFS_W-1:0]    arr_wr_ofs;
  logic [DATA_W-1:0]   arr_wr_data;

  assign ofs       = req_q.addr[OFS_W+1:2];
  assign idx       = req_q.addr[IDX_W+OFS_W+1:OFS_W+2];
  assign tag       = req_q.addr[ADDR_W-1:ADDR_W-TAG_W];
  assign hit       = rd_valid && (rd_tag == tag);
  assign ack_seen  = mem_req_q && mem.mem_ack;
  assign last_word = (cnt_q == OFS_W'(LINE_WORDS - 1));

  dcache_array #(.IDX_W(IDX_W), .OFS_W(OFS_W), .TAG_W(TAG_W)) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (idx),
    .rd_ofs_i   (ofs),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (arr_wr_en),
    .wr_idx_i   (idx),
    .wr_ofs_i   (arr_wr_ofs),
    .wr_data_i  (arr_wr_data),
    .line_set_i (line_set),
    .line_clr_i (line_clr),
    .line_tag_i (tag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (lsq.req_valid) state_d = LOOKUP;
      LOOKUP:  begin
        if (req_q.rw)  state_d = WRITE;
        else if (hit)  state_d = IDLE;
        else           state_d = REFILL;
      end
      REFILL:  if (ack_seen && last_word) state_d = LOOKUP;
      WRITE:   if (ack_seen) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = 1'b0;
    req_d        = req_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_cntrl_d = resp_cntrl_q;
    resp_z_d     = resp_z_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    arr_wr_en    = 1'b0;
    arr_wr_ofs   = ofs;
    arr_wr_data  = req_q.data;
    line_set     = 1'b0;
    line_clr     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (lsq.req_valid) begin
          req_d.rw    = lsq.req_rw;
          req_d.addr  = lsq.req_addr;
          req_d.data  = lsq.req_data;
          req_d.cntrl = lsq.req_cntrl;
          req_d.z     = lsq.req_z;
        end
      end
      LOOKUP: begin
        if (req_q.rw) begin
          // Write-through without allocate: a miss leaves the array untouched.
          arr_wr_en   = hit;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = req_q.addr & ~ADDR_W'(3);
          mem_wdata_d = req_q.data;
        end else if (hit) begin
          resp_valid_d = 1'b1;
          resp_data_d  = rd_data;
          resp_cntrl_d = req_q.cntrl;
          resp_z_d     = req_q.z;
        end else begin
          line_clr   = 1'b1;
          cnt_d      = '0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {req_q.addr[ADDR_W-1:OFS_W+2], {OFS_W{1'b0}}, 2'b00};
        end
      end
      REFILL: begin
        if (ack_seen) begin
          arr_wr_en   = 1'b1;
          arr_wr_ofs  = cnt_q;
          arr_wr_data = mem.mem_rdata;
          mem_req_d   = 1'b0;
          cnt_d       = cnt_q + OFS_W'(1);
          line_set    = last_word;
        end else if (!mem_req_q) begin
          // Idle cycle after each word; reissue for the next word here.
          mem_req_d  = 1'b1;
          mem_addr_d = {req_q.addr[ADDR_W-1:OFS_W+2], cnt_q, 2'b00};
        end
      end
      WRITE: begin
        if (ack_seen) begin
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_data_d  = '0;
          resp_cntrl_d = req_q.cntrl;
          resp_z_d     = req_q.z;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q        <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_cntrl_q <= '0;
      resp_z_q     <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      req_q        <= req_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_cntrl_q <= resp_cntrl_d;
      resp_z_q     <= resp_z_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign lsq.req_ready  = req_ready;
  assign lsq.resp_valid = resp_valid_q;
  assign lsq.resp_data  = resp_data_q;
  assign lsq.resp_cntrl = resp_cntrl_q;
  assign lsq.resp_z     = resp_z_q;
  assign mem.mem_req    = mem_req_q;
  assign mem.mem_we     = mem_we_q;
  assign mem.mem_addr   = mem_addr_q;
  assign mem.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed self-checking bench for dcache_ctrl
module tb_dcache_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_lsq_if lsq ();
  dcache_mem_if mem ();

  dcache_ctrl dut (
    .clk (clk),
    .rst (rst),
    .lsq (lsq.slave),
    .mem (mem.master)
  );

  int checks   = 0;
  int failures = 0;
  int resp_cnt = 0;
  int gap_viol = 0;
  int stab_viol = 0;

  logic        log_we    [$];
  logic [31:0] log_addr  [$];
  logic [31:0] log_wdata [$];
  logic [31:0] model [bit [31:0]];

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (model.exists(a)) return model[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic clear_log();
    log_we.delete();
    log_addr.delete();
    log_wdata.delete();
  endtask

  // Backing memory: acks two cycles after a request is seen, checks gap and hold rules.
  initial begin
    int          lat;
    logic        pend;
    logic [31:0] pa;
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = '0;
    lat  = 0;
    pend = 1'b0;
    pa   = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        mem.mem_ack = 1'b0;
        lat  = 0;
        pend = 1'b0;
      end else if (mem.mem_ack) begin
        mem.mem_ack = 1'b0;
        lat  = 0;
        pend = 1'b0;
        if (mem.mem_req === 1'b1) gap_viol++;
      end else if (mem.mem_req === 1'b1) begin
        if (pend && mem.mem_addr !== pa) stab_viol++;
        pend = 1'b1;
        pa   = mem.mem_addr;
        lat++;
        if (lat == 2) begin
          log_we.push_back(mem.mem_we);
          log_addr.push_back(mem.mem_addr);
          log_wdata.push_back(mem.mem_wdata);
          if (mem.mem_we) model[mem.mem_addr] = mem.mem_wdata;
          else mem.mem_rdata = mem_read(mem.mem_addr);
          mem.mem_ack = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (lsq.resp_valid === 1'b1) resp_cnt++;
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    lsq.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // lat = negedges after the accept edge until resp_valid is seen; -1 if none.
  task automatic do_req(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                        input logic [15:0] cntrl, input logic [3:0] z,
                        output logic [31:0] rdata, output logic [15:0] rcntrl,
                        output logic [3:0] rz, output int lat);
    int waited;
    lat    = -1;
    rdata  = '0;
    rcntrl = '0;
    rz     = '0;
    @(negedge clk);
    lsq.req_valid = 1'b1;
    lsq.req_rw    = rw;
    lsq.req_addr  = addr;
    lsq.req_data  = data;
    lsq.req_cntrl = cntrl;
    lsq.req_z     = z;
    waited = 0;
    while (lsq.req_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    @(negedge clk);
    lsq.req_valid = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      if (k > 1) @(negedge clk);
      if (lsq.resp_valid === 1'b1) begin
        lat    = k;
        rdata  = lsq.resp_data;
        rcntrl = lsq.resp_cntrl;
        rz     = lsq.resp_z;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({lsq.req_ready, lsq.resp_valid, mem.mem_req, mem.mem_we} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 1000", {lsq.req_ready, lsq.resp_valid, mem.mem_req, mem.mem_we});
    end
    checks++;
    if ({lsq.resp_data, lsq.resp_cntrl, lsq.resp_z} !== 52'h0) begin
      failures++;
      $display("FAIL reset_resp: got %h expected 0", {lsq.resp_data, lsq.resp_cntrl, lsq.resp_z});
    end
    checks++;
    if ({mem.mem_addr, mem.mem_wdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_mem: got %h expected 0", {mem.mem_addr, mem.mem_wdata});
    end
  endtask

  task automatic check_refill(input string name, input logic [31:0] base);
    checks++;
    if (log_addr.size() != 4) begin
      failures++;
      $display("FAIL %s_count: got %0d mem ops expected 4", name, log_addr.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= log_addr.size() || log_addr[i] !== base + 32'(4 * i) || log_we[i] !== 1'b0) begin
        failures++;
        $display("FAIL %s_word%0d: got addr %h expected read of %h", name, i,
                 (i < log_addr.size()) ? log_addr[i] : 32'hFFFF_FFFF, base + 32'(4 * i));
      end
    end
  endtask

  task automatic check_load(input string name, input logic [31:0] addr, input logic [31:0] exp,
                            input int exp_ops, input int exp_lat);
    logic [31:0] rd;
    logic [15:0] rc;
    logic [3:0]  rz;
    int          lat;
    clear_log();
    do_req(1'b0, addr, 32'h0, addr[15:0] ^ 16'h5A00, addr[5:2], rd, rc, rz, lat);
    checks++;
    if (lat < 1 || (exp_lat > 0 && lat != exp_lat)) begin
      failures++;
      $display("FAIL %s_lat: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (rd !== exp) begin
      failures++;
      $display("FAIL %s_data: got %h expected %h", name, rd, exp);
    end
    checks++;
    if (rc !== (addr[15:0] ^ 16'h5A00) || rz !== addr[5:2]) begin
      failures++;
      $display("FAIL %s_tags: got %h/%h expected %h/%h", name, rc, rz, addr[15:0] ^ 16'h5A00, addr[5:2]);
    end
    if (exp_ops == 0) begin
      checks++;
      if (log_addr.size() != 0) begin
        failures++;
        $display("FAIL %s_nomem: got %0d mem ops expected 0", name, log_addr.size());
      end
    end
  endtask

  task automatic check_store(input string name, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    logic [15:0] rc;
    logic [3:0]  rz;
    int          lat;
    clear_log();
    do_req(1'b1, addr, data, 16'hC0DE, 4'h9, rd, rc, rz, lat);
    checks++;
    if (lat < 1 || rd !== 32'h0 || rc !== 16'hC0DE || rz !== 4'h9) begin
      failures++;
      $display("FAIL %s_ack: got lat %0d data %h tags %h/%h expected ack data 0 tags c0de/9", name, lat, rd, rc, rz);
    end
    checks++;
    if (log_addr.size() != 1 || log_we[0] !== 1'b1 || log_addr[0] !== addr || log_wdata[0] !== data) begin
      failures++;
      $display("FAIL %s_mem: got %0d ops first %h expected one write %h=%h", name, log_addr.size(),
               (log_addr.size() > 0) ? log_addr[0] : 32'hFFFF_FFFF, addr, data);
    end
  endtask

  task automatic test_cold_load();
    check_load("cold", 32'h0000_0104, 32'hA1, 4, 0);
    check_refill("cold", 32'h0000_0100);
  endtask

  task automatic test_hit();
    check_load("hit", 32'h0000_010C, 32'hA3, 0, 2);
  endtask

  task automatic test_store_hit();
    check_store("st_hit", 32'h0000_0108, 32'hDEAD_BEEF);
    check_load("st_hit_rd", 32'h0000_0108, 32'hDEAD_BEEF, 0, 2);
  endtask

  task automatic test_store_miss();
    check_store("st_miss", 32'h0000_2000, 32'h1122_3344);
    check_load("st_miss_rd", 32'h0000_2000, 32'h1122_3344, 4, 0);
    check_refill("st_miss_rd", 32'h0000_2000);
  endtask

  task automatic test_conflict();
    check_load("evict", 32'h0000_1104, 32'hB1, 4, 0);
    check_refill("evict", 32'h0000_1100);
    check_load("reload", 32'h0000_0104, 32'hA1, 4, 0);
    check_refill("reload", 32'h0000_0100);
  endtask

  task automatic test_back_to_back();
    check_load("b2b_a", 32'h0000_0100, 32'hA0, 0, 2);
    check_load("b2b_b", 32'h0000_0108, 32'hDEAD_BEEF, 0, 2);
  endtask

  task automatic test_reset_mid_refill();
    int saved;
    int n;
    apply_reset();
    clear_log();
    @(negedge clk);
    lsq.req_valid = 1'b1;
    lsq.req_rw    = 1'b0;
    lsq.req_addr  = 32'h0000_0104;
    lsq.req_cntrl = 16'h0006;
    lsq.req_z     = 4'h6;
    @(posedge clk);
    @(negedge clk);
    lsq.req_valid = 1'b0;
    n = 0;
    while (!(log_addr.size() == 1 && mem.mem_req === 1'b1 && mem.mem_ack === 1'b0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL rstmid_wait: got no second refill word within 100 cycles expected one");
    end
    saved = resp_cnt;
    rst = 1'b1;
    #1;
    checks++;
    if (mem.mem_req !== 1'b0 || lsq.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_async: got mem_req %b req_ready %b expected 0 1", mem.mem_req, lsq.req_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (resp_cnt != saved || log_addr.size() != 1) begin
      failures++;
      $display("FAIL rstmid_quiet: got %0d resp %0d mem ops expected 0 resp 1 mem op", resp_cnt - saved, log_addr.size());
    end
    check_load("rstmid_reload", 32'h0000_0104, 32'hA1, 4, 0);
    check_refill("rstmid_reload", 32'h0000_0100);
  endtask

  task automatic test_protocol();
    checks++;
    if (gap_viol != 0 || stab_viol != 0) begin
      failures++;
      $display("FAIL protocol: got %0d gap and %0d hold violations expected 0", gap_viol, stab_viol);
    end
  endtask

  initial begin
    rst = 1'b1;
    lsq.req_valid = 1'b0;
    lsq.req_rw    = 1'b0;
    lsq.req_addr  = '0;
    lsq.req_data  = '0;
    lsq.req_cntrl = '0;
    lsq.req_z     = '0;
    for (int i = 0; i < 4; i++) begin
      model[32'h0000_0100 + 32'(4 * i)] = 32'hA0 + 32'(i);
      model[32'h0000_1100 + 32'(4 * i)] = 32'hB0 + 32'(i);
    end
    test_reset();
    test_cold_load();
    test_hit();
    test_store_hit();
    test_store_miss();
    test_conflict();
    test_back_to_back();
    test_reset_mid_refill();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
